// File: rtl/pipeline_hazard_controller_pkg.sv
// Shared encodings for the 5-stage pipeline hazard controller.
package pipeline_hazard_controller_pkg;

    localparam int unsigned REG_WIDTH = 5;
    localparam int unsigned FWD_WIDTH = 2;

    localparam logic [FWD_WIDTH-1:0] FWD_REGFILE = 2'b00;
    localparam logic [FWD_WIDTH-1:0] FWD_MEMWB   = 2'b01;
    localparam logic [FWD_WIDTH-1:0] FWD_EXMEM   = 2'b10;

    localparam logic [REG_WIDTH-1:0] REG_ZERO = 5'd0;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2
    } ctrlState_t;

endpackage

// File: rtl/pipeline_hazard_controller_forwarding_unit.sv
// EX-stage operand forwarding selects; EX/MEM wins over MEM/WB, $0 never forwarded.
module pipeline_hazard_controller_forwarding_unit
    import pipeline_hazard_controller_pkg::*;
(
    input  logic [4:0] ex_rs,
    input  logic [4:0] ex_rt,
    input  logic       mem_reg_write,
    input  logic [4:0] mem_write_reg,
    input  logic       wb_reg_write,
    input  logic [4:0] wb_write_reg,
    output logic [1:0] forward_a,
    output logic [1:0] forward_b
);

    logic memHitA, memHitB, wbHitA, wbHitB;

    always_comb begin
        memHitA = mem_reg_write && (mem_write_reg != REG_ZERO) && (mem_write_reg == ex_rs);
        memHitB = mem_reg_write && (mem_write_reg != REG_ZERO) && (mem_write_reg == ex_rt);
        wbHitA  = wb_reg_write  && (wb_write_reg  != REG_ZERO) && (wb_write_reg  == ex_rs);
        wbHitB  = wb_reg_write  && (wb_write_reg  != REG_ZERO) && (wb_write_reg  == ex_rt);
    end

    always_comb begin
        forward_a = FWD_REGFILE;
        forward_b = FWD_REGFILE;
        if (memHitA)     forward_a = FWD_EXMEM;
        else if (wbHitA) forward_a = FWD_MEMWB;
        if (memHitB)     forward_b = FWD_EXMEM;
        else if (wbHitB) forward_b = FWD_MEMWB;
    end

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Load-use stall, taken-branch flush and forwarding control for the MIPS pipeline,
// with saturating stall/flush counters and a sticky protocol-error flag.
module pipeline_hazard_controller
    import pipeline_hazard_controller_pkg::*;
#(
    parameter int unsigned CNT_WIDTH = 16
)
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic [4:0]           id_rs,
    input  logic [4:0]           id_rt,
    input  logic                 id_uses_rt,
    input  logic [4:0]           ex_rs,
    input  logic [4:0]           ex_rt,
    input  logic                 ex_mem_read,
    input  logic [4:0]           ex_write_reg,
    input  logic                 mem_reg_write,
    input  logic [4:0]           mem_write_reg,
    input  logic                 wb_reg_write,
    input  logic [4:0]           wb_write_reg,
    input  logic                 branch_taken_mem,
    output logic                 pc_enable,
    output logic                 if_id_enable,
    output logic                 if_id_flush,
    output logic                 id_ex_flush,
    output logic                 ex_mem_flush,
    output logic [1:0]           forward_a,
    output logic [1:0]           forward_b,
    output logic [CNT_WIDTH-1:0] stall_count,
    output logic [CNT_WIDTH-1:0] flush_count,
    output logic                 proto_error
);

    ctrlState_t state, stateNext;
    logic       hz, br;
    logic [1:0] fwdA, fwdB;

    pipeline_hazard_controller_forwarding_unit forwardingUnit (
        .ex_rs         (ex_rs),
        .ex_rt         (ex_rt),
        .mem_reg_write (mem_reg_write),
        .mem_write_reg (mem_write_reg),
        .wb_reg_write  (wb_reg_write),
        .wb_write_reg  (wb_write_reg),
        .forward_a     (fwdA),
        .forward_b     (fwdB)
    );

    // In FLUSH the MEM stage carries the bubble we injected, so its branch flag is stale.
    always_comb begin
        hz = ex_mem_read && (ex_write_reg != REG_ZERO) &&
             ((ex_write_reg == id_rs) || (id_uses_rt && (ex_write_reg == id_rt)));
        br = branch_taken_mem && (state != FLUSH);
    end

    always_comb begin
        stateNext    = RUN;
        pc_enable    = 1'b1;
        if_id_enable = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        forward_a    = fwdA;
        forward_b    = fwdB;
        if (br) begin
            stateNext    = FLUSH;
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
        end else if (hz) begin
            stateNext    = STALL;
            pc_enable    = 1'b0;
            if_id_enable = 1'b0;
            id_ex_flush  = 1'b1;
        end
        // Reset holds the pipeline frozen and filled with bubbles.
        if (reset) begin
            pc_enable    = 1'b0;
            if_id_enable = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
            forward_a    = FWD_REGFILE;
            forward_b    = FWD_REGFILE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= RUN;
            stall_count <= '0;
            flush_count <= '0;
            proto_error <= 1'b0;
        end else begin
            state <= stateNext;
            if (hz && !br && (stall_count != '1))
                stall_count <= stall_count + CNT_WIDTH'(1);
            if (br && (flush_count != '1))
                flush_count <= flush_count + CNT_WIDTH'(1);
            // A single load can only cause one stall; back-to-back means broken upstream control.
            if (hz && (state == STALL))
                proto_error <= 1'b1;
        end
    end

endmodule

// File: doc/pipeline_hazard_controller.md
Name: pipeline_hazard_controller

Overview:
Hazard and sequencing controller for the 5-stage MIPS pipeline (IF/ID/EX/MEM/WB).
- Detects load-use hazards and stalls PC and IF/ID while injecting a bubble into ID/EX.
- Flushes the three younger stages when a branch resolves taken in MEM.
- Produces EX-stage operand forwarding selects.
- Keeps saturating stall/flush performance counters and a sticky protocol-error flag.
- Sits beside the pipeline registers and drives their enable/flush inputs.

Parameters:
- CNT_WIDTH, 16, width of stall_count and flush_count.

Ports:
- clk  input  1  pipeline clock
- reset  input  1  asynchronous, active-high reset
- id_rs  input  5  rs field of instruction in ID
- id_rt  input  5  rt field of instruction in ID
- id_uses_rt  input  1  ID instruction reads rt (R-type, beq/bne, sw)
- ex_rs  input  5  rs of instruction in EX
- ex_rt  input  5  rt of instruction in EX
- ex_mem_read  input  1  EX instruction is a load
- ex_write_reg  input  5  destination register of EX instruction
- mem_reg_write  input  1  MEM instruction writes register file
- mem_write_reg  input  5  MEM destination register
- wb_reg_write  input  1  WB instruction writes register file
- wb_write_reg  input  5  WB destination register
- branch_taken_mem  input  1  branch in MEM resolved taken; PC mux selects target
- pc_enable  output  1  PC register load enable
- if_id_enable  output  1  IF/ID register load enable
- if_id_flush  output  1  IF/ID loads zeros (nop)
- id_ex_flush  output  1  ID/EX loads zeros (bubble)
- ex_mem_flush  output  1  EX/MEM loads zeros
- forward_a  output  2  EX operand A select: 00 regfile, 01 MEM/WB, 10 EX/MEM
- forward_b  output  2  EX operand B select, same encoding
- stall_count  output  CNT_WIDTH  load-use stall cycles, saturating
- flush_count  output  CNT_WIDTH  branch flush events, saturating
- proto_error  output  1  sticky error flag

Behaviour:
- Control outputs are combinational from inputs and state and take effect at the same clk edge. Counters, state and proto_error are registered.
- While reset is high:
  - pc_enable=0, if_id_enable=0.
  - if_id_flush, id_ex_flush and ex_mem_flush are all 1.
  - forward_a and forward_b are 00.
  - state=RUN, counters=0, proto_error=0.
- Load-use hazard (hz) is true when all of these hold:
  - ex_mem_read=1;
  - ex_write_reg != 0;
  - ex_write_reg == id_rs, or (id_uses_rt and ex_write_reg == id_rt).
- Branch flush (br) is true when branch_taken_mem=1 and state != FLUSH. In state FLUSH the MEM stage holds a bubble, so branch_taken_mem is ignored.
- Priority: br over hz.
  - br: pc_enable=1, if_id_enable=1, all three flushes=1.
  - hz and not br: pc_enable=0, if_id_enable=0, id_ex_flush=1, other flushes=0.
  - Neither: pc_enable=1, if_id_enable=1, all flushes=0.
- FSM, states RUN, STALL, FLUSH:
  - Next state: FLUSH if br; else STALL if hz; else RUN.
  - If hz is true while state=STALL, that is a second consecutive load-use stall, which is impossible for a single load. proto_error is set and stays set until reset. The stall is still applied.
- Counters:
  - stall_count increments by 1 on each cycle with hz and not br.
  - flush_count increments by 1 on each cycle with br.
  - Both saturate at all-ones and never wrap.
- Forwarding, evaluated for operand A (ex_rs) and B (ex_rt):
  - 10 if mem_reg_write, mem_write_reg != 0 and mem_write_reg == src.
  - Else 01 if wb_reg_write, wb_write_reg != 0 and wb_write_reg == src.
  - Else 00.
  - EX/MEM has priority over MEM/WB. Register 0 is never forwarded.
- Reset deassertion mid-stream: the first cycle after reset evaluates normally from state RUN.

Decomposition:
- Shared package holds:
  - forwarding select constants FWD_REGFILE=2'b00, FWD_MEMWB=2'b01, FWD_EXMEM=2'b10;
  - state encoding RUN/STALL/FLUSH;
  - REG_ZERO=5'd0.
- One sub-module is natural: forwarding_unit, purely combinational, instanced once and producing forward_a and forward_b. The FSM and counters stay in the top.

Test Plan:
- Load-use on rs: ex_mem_read=1, ex_write_reg=8, id_rs=8 → pc_enable=0, if_id_enable=0, id_ex_flush=1 for one cycle; stall_count 0→1. Next cycle hz=0 → normal flow, state RUN.
- Write to $0 is ignored: ex_mem_read=1, ex_write_reg=0, id_rs=0 → no stall. mem_reg_write=1, mem_write_reg=0, ex_rs=0 → forward_a=00.
- Branch beats stall:
  - Cycle 1: branch_taken_mem=1 together with a load-use hazard → all three flushes=1, pc_enable=1, flush_count=1, stall_count unchanged.
  - Cycle 2: branch_taken_mem still held at 1 → ignored (state FLUSH), flushes=0.
- Forward priority: mem_write_reg=9 and wb_write_reg=9, both writing, ex_rs=9, ex_rt=9 → forward_a=10, forward_b=10. Drop mem_reg_write → both 01.
- Saturation and error:
  - With CNT_WIDTH=2, four stalls separated by RUN cycles → stall_count sticks at 3.
  - A hazard held for two consecutive cycles → proto_error=1, stays 1 until reset.
- Async reset: assert reset mid-stall, off the clock edge → outputs take their reset values immediately, counters read 0 and proto_error reads 0 before the next clk edge.
